seg_capture: RTL and testbench

Reader for the multiplexed 8-digit seven-segment bus. Samples `display_data`/`display_en` as driven by the segment display driver and reconstructs the 32-bit hex word being shown, one nibble per digit. Sits beside the display driver on the board top, or in the CPU bench, as a loopback checker. Also feeds the displayed value back into the design for self-test.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_decode.sv | 25 ++
 rtl/seg_capture.sv | 163 ++++++++++++++++
 tb/tb_seg_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture path: hex segment table,
// pattern/select typedefs and the blank pattern.
package seg_pkg;

  typedef logic [7:0] seg_pattern_t;
  typedef logic [7:0] digit_sel_t;

  localparam seg_pattern_t SEG_BLANK  = 8'hFF;
  localparam int unsigned  NumDigits  = 8;

  // Active-low segments, dp off, digits 0..F
  localparam seg_pattern_t SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // True when exactly one active-low enable is asserted
  function automatic logic sel_is_single(digit_sel_t sel);
    return $onehot(~sel);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational segment-pattern to hex-nibble lookup; the dp bit is ignored.
module seg_decode
  import seg_pkg::*;
(
  input  seg_pattern_t i_pattern,
  output logic         o_valid,
  output logic [3:0]   o_nibble
);

  seg_pattern_t w_masked;

  assign w_masked = i_pattern | 8'h80;

  always_comb begin
    o_valid  = 1'b0;
    o_nibble = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (w_masked == SEG_HEX[k]) begin
        o_valid  = 1'b1;
        o_nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Reconstructs the 32-bit hex word shown on a multiplexed 8-digit display bus.
// Optional dp capture is enabled by defining SEG_CAPTURE_DP_EN.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sample_en,
  input  logic [7:0]   display_data,
  input  logic [7:0]   display_en,
  output logic [31:0]  datas,
  output logic [7:0]   dp,
  output logic         frame_valid,
  output logic         changed,
  output logic         err_pattern,
  output logic         err_enable
);

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  logic [31:0]   r_datas;
  logic [31:0]   r_shadow;
  logic [7:0]    r_seen;
  logic [3:0]    r_cnt;
  digit_sel_t    r_prev_en;
  seg_pattern_t  r_prev_data;
  logic          r_frame_valid;
  logic          r_changed;
  logic          r_err_pattern;
  logic          r_err_enable;

  seg_pattern_t  w_key;
  logic          w_blank;
  logic          w_single;
  logic          w_run;
  logic [3:0]    w_cnt_next;
  logic          w_accept;
  logic          w_dec_valid;
  logic [3:0]    w_dec_nibble;
  logic          w_slot_we;
  logic [7:0]    w_seen_next;
  logic [31:0]   w_shadow_next;
  logic          w_complete;

`ifdef SEG_CAPTURE_DP_EN
  assign w_key = display_data;
`else
  // dp is forced off so it never breaks a settle run
  assign w_key = display_data | 8'h80;
`endif

  assign w_blank  = (display_en == SEG_BLANK);
  assign w_single = sel_is_single(display_en);
  assign w_run    = (display_en == r_prev_en) && (w_key == r_prev_data);

  always_comb begin
    w_cnt_next = 4'd1;
    if (w_run) begin
      w_cnt_next = (r_cnt == SettleCnt) ? r_cnt : r_cnt + 4'd1;
    end
  end

  // A saturated run that keeps repeating must not re-accept
  assign w_accept = sample_en && w_single && (w_cnt_next == SettleCnt) &&
                    !(w_run && (r_cnt == SettleCnt));

  seg_decode u_decode (
    .i_pattern (display_data),
    .o_valid   (w_dec_valid),
    .o_nibble  (w_dec_nibble)
  );

  assign w_slot_we   = w_accept && w_dec_valid;
  assign w_seen_next = r_seen | (w_slot_we ? ~display_en : 8'h00);
  assign w_complete  = w_slot_we && (w_seen_next == 8'hFF);

  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < NumDigits; i++) begin
      if (w_slot_we && !display_en[i]) begin
        w_shadow_next[4*i +: 4] = w_dec_nibble;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_datas       <= '0;
      r_shadow      <= '0;
      r_seen        <= '0;
      r_cnt         <= '0;
      r_prev_en     <= SEG_BLANK;
      r_prev_data   <= SEG_BLANK;
      r_frame_valid <= 1'b0;
      r_changed     <= 1'b0;
      r_err_pattern <= 1'b0;
      r_err_enable  <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_changed     <= 1'b0;
      if (sample_en) begin
        r_prev_en   <= display_en;
        r_prev_data <= w_key;
        r_cnt       <= w_single ? w_cnt_next : 4'd0;
        r_shadow    <= w_shadow_next;
        if (!w_blank && !w_single) begin
          r_err_enable <= 1'b1;
        end
        if (w_accept && !w_dec_valid) begin
          r_err_pattern <= 1'b1;
        end
        if (w_complete) begin
          r_datas       <= w_shadow_next;
          r_frame_valid <= 1'b1;
          r_changed     <= (w_shadow_next != r_datas);
          r_seen        <= '0;
        end else begin
          r_seen <= w_seen_next;
        end
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic [7:0] r_dp_shadow;
  logic [7:0] r_dp;
  logic [7:0] w_dp_shadow_next;

  always_comb begin
    w_dp_shadow_next = r_dp_shadow;
    for (int i = 0; i < NumDigits; i++) begin
      if (w_slot_we && !display_en[i]) begin
        w_dp_shadow_next[i] = ~display_data[7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_dp_shadow <= '0;
      r_dp        <= '0;
    end else if (sample_en) begin
      r_dp_shadow <= w_dp_shadow_next;
      if (w_complete) begin
        r_dp <= w_dp_shadow_next;
      end
    end
  end

  assign dp = r_dp;
`else
  assign dp = 8'h00;
`endif

  assign datas       = r_datas;
  assign frame_valid = r_frame_valid;
  assign changed     = r_changed;
  assign err_pattern = r_err_pattern;
  assign err_enable  = r_err_enable;

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed frames plus random scan traffic
// compared every cycle against a behavioural model.
module tb_seg_capture;

  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        sample_en;
  logic [7:0]  display_data;
  logic [7:0]  display_en;
  logic [31:0] datas;
  logic [7:0]  dp;
  logic        frame_valid;
  logic        changed;
  logic        err_pattern;
  logic        err_enable;

  seg_capture #(.SETTLE(SETTLE)) dut (
    .clk          (clk),
    .clr          (clr),
    .sample_en    (sample_en),
    .display_data (display_data),
    .display_en   (display_en),
    .datas        (datas),
    .dp           (dp),
    .frame_valid  (frame_valid),
    .changed      (changed),
    .err_pattern  (err_pattern),
    .err_enable   (err_enable)
  );

  always #5 clk = ~clk;

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_checks = 0;
  int n_errors = 0;
  int fv_seen  = 0;
  int ch_seen  = 0;

  // Model state
  logic [31:0] m_datas, m_sh;
  logic [7:0]  m_dp, m_shdp, m_seen, m_prev_en, m_prev_d;
  logic        m_fv, m_ch, m_ep, m_ee;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_datas = '0; m_sh = '0; m_dp = '0; m_shdp = '0; m_seen = '0;
    m_prev_en = 8'hFF; m_prev_d = 8'hFF;
    m_fv = 0; m_ch = 0; m_ep = 0; m_ee = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic c, input logic s, input logic [7:0] e,
                            input logic [7:0] d);
    logic [7:0] key;
    logic       run, found;
    int         old, idx, nib;
    if (c) begin
      model_reset();
      return;
    end
    m_fv = 0;
    m_ch = 0;
    if (!s) return;
`ifdef SEG_CAPTURE_DP_EN
    key = d;
`else
    key = d | 8'h80;
`endif
    if (e == 8'hFF) begin
      m_cnt = 0;
    end else if ($countones(~e) != 1) begin
      m_ee  = 1;
      m_cnt = 0;
    end else begin
      run   = (e == m_prev_en) && (key == m_prev_d);
      old   = m_cnt;
      m_cnt = run ? ((old < SETTLE) ? old + 1 : SETTLE) : 1;
      if (m_cnt == SETTLE && !(run && old == SETTLE)) begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (!e[i]) idx = i;
        found = 0;
        nib   = 0;
        for (int k = 0; k < 16; k++) begin
          if (HEX[k][6:0] == d[6:0]) begin
            found = 1;
            nib   = k;
          end
        end
        if (!found) begin
          m_ep = 1;
        end else begin
          m_sh[4*idx +: 4] = 4'(nib);
          m_shdp[idx]      = ~d[7];
          m_seen[idx]      = 1'b1;
          if (m_seen == 8'hFF) begin
            m_ch    = (m_sh != m_datas);
            m_datas = m_sh;
`ifdef SEG_CAPTURE_DP_EN
            m_dp    = m_shdp;
`else
            m_dp    = 8'h00;
`endif
            m_fv    = 1;
            m_seen  = '0;
          end
        end
      end
    end
    m_prev_en = e;
    m_prev_d  = key;
  endtask

  // Single compare process: advance the model on each edge, check 1 ns later
  always @(posedge clk) begin
    model_step(clr, sample_en, display_en, display_data);
    #1;
    chk("datas", datas, m_datas);
    chk("dp", {24'd0, dp}, {24'd0, m_dp});
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
    chk("changed", {31'd0, changed}, {31'd0, m_ch});
    chk("err_pattern", {31'd0, err_pattern}, {31'd0, m_ep});
    chk("err_enable", {31'd0, err_enable}, {31'd0, m_ee});
    if (frame_valid === 1'b1) fv_seen++;
    if (changed === 1'b1) ch_seen++;
  end

  task automatic drive(input logic c, input logic s, input logic [7:0] e, input logic [7:0] d);
    clr = c; sample_en = s; display_en = e; display_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [7:0] e, input logic [7:0] d);
    drive(1'b0, 1'b1, e, d);
    drive(1'b0, 1'b0, e, d);
  endtask

  task automatic show(input int i, input int nib, input int reps);
    logic [7:0] sel;
    sel = 8'(~(8'd1 << i));
    repeat (reps) strobe(sel, HEX[nib]);
  endtask

  task automatic show_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) show(i, int'(w[4*i +: 4]), 2);
    drive(1'b0, 1'b0, 8'hFF, 8'hFF);
  endtask

  task automatic pulses(input string name, input int fv, input int ch);
    chk({name, "_fv_count"}, 32'(fv_seen), 32'(fv));
    chk({name, "_ch_count"}, 32'(ch_seen), 32'(ch));
    fv_seen = 0;
    ch_seen = 0;
  endtask

  initial begin
    logic [31:0] gw;
    clr = 1'b1; sample_en = 1'b0; display_en = 8'hFF; display_data = 8'hFF;
    model_reset();
    @(posedge clk); #2;
    drive(1'b1, 1'b0, 8'hFF, 8'hFF);
    chk("reset_datas", datas, 32'h0);
    chk("reset_err", {30'd0, err_pattern, err_enable}, 32'h0);
    fv_seen = 0; ch_seen = 0;

    show_word(32'h12345678);
    chk("frame1_datas", datas, 32'h12345678);
    pulses("frame1", 1, 1);

    show_word(32'h12345678);
    chk("frame2_datas", datas, 32'h12345678);
    pulses("frame2", 1, 0);

    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        strobe(8'hF7, 8'hFF);
        strobe(8'hF7, 8'hFF);
      end else begin
        show(i, 8 - i, 2);
      end
    end
    chk("badpat_err", {31'd0, err_pattern}, 32'd1);
    chk("badpat_datas", datas, 32'h12345678);
    pulses("badpat", 0, 0);

    show(3, 4'hA, 2);
    chk("fill3_datas", datas, 32'h1234A678);
    pulses("fill3", 1, 1);

    strobe(8'hFC, HEX[1]);
    chk("multi_en_err", {31'd0, err_enable}, 32'd1);
    show_word(32'h630DA741);
    chk("after_multi_datas", datas, 32'h630DA741);
    pulses("after_multi", 1, 1);

    gw = 32'h0F1E2D3C;
    for (int i = 0; i < 8; i++) begin
      show(i, int'(gw[4*i +: 4]), 2);
      if (i == 3) strobe(8'hDF, HEX[9]);
    end
    chk("glitch_datas", datas, 32'h0F1E2D3C);
    pulses("glitch", 1, 1);

    for (int i = 0; i < 5; i++) show(i, 7, 2);
    drive(1'b1, 1'b1, 8'hFE, HEX[3]);
    chk("clr_datas", datas, 32'h0);
    chk("clr_err", {30'd0, err_pattern, err_enable}, 32'h0);
    for (int i = 0; i < 7; i++) show(i, int'(gw[4*i +: 4]) ^ 5, 2);
    pulses("clr_partial", 0, 0);
    show_word(32'hCAFEF00D);
    chk("clr_fresh_datas", datas, 32'hCAFEF00D);
    pulses("clr_fresh", 1, 1);

    // Random scan traffic, including dp bits, glitches, errors and resets
    for (int n = 0; n < 1500; n++) begin
      int op;
      logic [7:0] d;
      op = int'($urandom_range(0, 99));
      d  = HEX[$urandom_range(0, 15)] & {($urandom_range(0, 3) != 0), 7'h7F};
      if (op < 70) begin
        repeat ($urandom_range(1, 3)) begin
          drive(1'b0, 1'b1, 8'(~(8'd1 << (n % 8))), d);
          repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 8'hFF, 8'hFF);
        end
      end else if (op < 78) begin
        strobe(8'(~(8'd1 << $urandom_range(0, 7))), 8'($urandom()));
      end else if (op < 84) begin
        strobe(8'hFF, d);
      end else if (op < 88) begin
        strobe(8'($urandom()) & 8'(~(8'd1 << $urandom_range(0, 7))), d);
      end else if (op < 98) begin
        drive(1'b0, 1'b0, 8'($urandom()), 8'($urandom()));
      end else begin
        drive(1'b1, 1'($urandom_range(0, 1)), 8'hFE, HEX[0]);
      end
    end
    drive(1'b0, 1'b0, 8'hFF, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
